// File: rtl/reg_write_arbiter_rr.sv
// reg_write_arbiter_rr: round-robin arbiter owning writes to one shared WIDTH-bit register.
// Define ARB_LOCK_EN to let a granted requester hold ownership across cycles via lock.
module reg_write_arbiter_rr #(
    parameter int NREQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     data,
    input  logic [NREQ-1:0]           lock,
    output logic [NREQ-1:0]           grant,
    output logic [WIDTH-1:0]          q,
    output logic [$clog2(NREQ)-1:0]   q_owner,
    output logic                      q_valid
);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] ptr, ptr_n, rr_idx, g;
    logic          rr_hit, hit, adv;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
    endfunction

    // First requesting index at or after ptr, wrapping around.
    always_comb begin
        logic [PW-1:0] j;
        rr_hit = 1'b0;
        rr_idx = '0;
        j = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = PW'((int'(ptr) + k) % NREQ);
            if (!rr_hit && req[j]) begin
                rr_hit = 1'b1;
                rr_idx = j;
            end
        end
    end

`ifdef ARB_LOCK_EN
    typedef enum logic {UNLOCKED, LOCKED} state_t;
    state_t        state, state_n;
    logic [PW-1:0] owner, owner_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= UNLOCKED;
            owner <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
        end
    end

    // While locked the owner keeps the register reserved even when not requesting.
    always_comb begin
        state_n = state;
        owner_n = owner;
        g       = rr_idx;
        hit     = rr_hit;
        ptr_n   = nxt(rr_idx);
        adv     = rr_hit;
        if (state == LOCKED) begin
            g     = owner;
            hit   = req[owner];
            ptr_n = nxt(owner);
            adv   = !lock[owner];
            if (!lock[owner])
                state_n = UNLOCKED;
        end else if (rr_hit && lock[rr_idx]) begin
            state_n = LOCKED;
            owner_n = rr_idx;
            adv     = 1'b0;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^lock;

    always_comb begin
        g     = rr_idx;
        hit   = rr_hit;
        ptr_n = nxt(rr_idx);
        adv   = rr_hit;
    end
`endif

    assign grant = (rst || !hit) ? '0 : NREQ'(1) << g;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            q_owner <= '0;
            q_valid <= 1'b0;
            ptr     <= '0;
        end else begin
            if (hit) begin
                q       <= data[g*WIDTH +: WIDTH];
                q_owner <= g;
                q_valid <= 1'b1;
            end
            if (adv)
                ptr <= ptr_n;
        end
    end
endmodule

// File: tb/tb_reg_write_arbiter_rr.sv
// tb_reg_write_arbiter_rr: directed checks of grant order, write, hold, reset and lock.
module tb_reg_write_arbiter_rr;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, lock, grant;
    logic [31:0] data;
    logic [7:0]  q;
    logic [1:0]  q_owner;
    logic        q_valid;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    reg_write_arbiter_rr #(.NREQ(4), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .lock(lock),
        .grant(grant), .q(q), .q_owner(q_owner), .q_valid(q_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check same-cycle grant, then the registered result.
    task automatic cyc(input string tag, input logic [3:0] r, input logic [3:0] l, input logic [31:0] d,
                       input logic [3:0] eg, input logic [7:0] eq, input logic [1:0] eo);
        @(negedge clk);
        req = r;
        lock = l;
        data = d;
        #1 chk({tag, "/grant"}, 32'(grant), 32'(eg));
        @(posedge clk);
        #1;
        chk({tag, "/q"}, 32'(q), 32'(eq));
        chk({tag, "/q_owner"}, 32'(q_owner), 32'(eo));
        chk({tag, "/q_valid"}, 32'(q_valid), 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "/grant"}, 32'(grant), 32'd0);
        chk({tag, "/q"}, 32'(q), 32'd0);
        chk({tag, "/q_owner"}, 32'(q_owner), 32'd0);
        chk({tag, "/q_valid"}, 32'(q_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b1111;
        lock = 4'b0000;
        data = 32'h0;
        #2 chk_reset("por");
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0000;

        cyc("single", 4'b0001, 4'b0000, 32'h000000A5, 4'b0001, 8'hA5, 2'd0);

        @(negedge clk);
        req = 4'b1111;
        #2 rst = 1'b1;
        #1 chk_reset("mid_rst1");
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0000;

        for (int i = 0; i < 8; i++)
            cyc("contend", 4'b1111, 4'b0000, 32'h13121110,
                4'(1 << (i % 4)), 8'(8'h10 + i % 4), 2'(i % 4));

        cyc("wrap_a", 4'b0100, 4'b0000, 32'h00220000, 4'b0100, 8'h22, 2'd2);
        cyc("wrap_b", 4'b0101, 4'b0000, 32'h00320030, 4'b0001, 8'h30, 2'd0);
        cyc("wrap_c", 4'b0101, 4'b0000, 32'h00320030, 4'b0100, 8'h32, 2'd2);

        cyc("hold_w", 4'b1000, 4'b0000, 32'h3C000000, 4'b1000, 8'h3C, 2'd3);
        for (int i = 0; i < 5; i++)
            cyc("idle", 4'b0000, 4'b0000, 32'hFFFFFFFF, 4'b0000, 8'h3C, 2'd3);

        cyc("lock_pre", 4'b0001, 4'b0000, 32'h53525150, 4'b0001, 8'h50, 2'd0);
`ifdef ARB_LOCK_EN
        cyc("lock_c1", 4'b0011, 4'b0010, 32'h53525150, 4'b0010, 8'h51, 2'd1);
        cyc("lock_c2", 4'b0011, 4'b0010, 32'h53525150, 4'b0010, 8'h51, 2'd1);
        cyc("lock_c3", 4'b0011, 4'b0010, 32'h53525150, 4'b0010, 8'h51, 2'd1);
        cyc("unlock",  4'b0011, 4'b0000, 32'h53525150, 4'b0010, 8'h51, 2'd1);
        cyc("after",   4'b0111, 4'b0000, 32'h53525150, 4'b0100, 8'h52, 2'd2);
`else
        cyc("lock_c1", 4'b0011, 4'b0010, 32'h53525150, 4'b0010, 8'h51, 2'd1);
        cyc("lock_c2", 4'b0011, 4'b0010, 32'h53525150, 4'b0001, 8'h50, 2'd0);
        cyc("lock_c3", 4'b0011, 4'b0010, 32'h53525150, 4'b0010, 8'h51, 2'd1);
        cyc("unlock",  4'b0011, 4'b0000, 32'h53525150, 4'b0001, 8'h50, 2'd0);
        cyc("after",   4'b0111, 4'b0000, 32'h53525150, 4'b0010, 8'h51, 2'd1);
`endif

        @(negedge clk);
        req = 4'b1111;
        #2 rst = 1'b1;
        #1 chk_reset("mid_rst2");
        @(posedge clk);
        #1 chk_reset("rst_held");
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst/grant", 32'(grant), 32'b0001);
        @(posedge clk);
        #1;
        chk("post_rst/q", 32'(q), 32'h50);
        chk("post_rst/q_owner", 32'(q_owner), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/reg_write_arbiter_rr.md
Name: reg_write_arbiter_rr

Overview:
- Round-robin arbiter that shares one WIDTH-bit edge-triggered storage register among NREQ requesters.
- Each cycle it grants at most one requester. On the rising clk edge it writes that requester's data into the register.
- Sits in front of a shared flop-based register, for example a shared status or accumulator register.
- It is the sequencing/ownership logic for that resource.

Parameters:
- NREQ, 4, number of requesters; legal range 2..16.
- WIDTH, 8, data width of the shared register in bits.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester write request; bit i belongs to requester i.
- data  input  NREQ*WIDTH  packed write data; requester i uses bits [i*WIDTH +: WIDTH].
- lock  input  NREQ  per-requester grant-hold request; used only when ARB_LOCK_EN is defined, ignored otherwise.
- grant  output  NREQ  one-hot (or zero) grant, combinational in the same cycle as req.
- q  output  WIDTH  shared register contents.
- q_owner  output  $clog2(NREQ)  index of the requester that performed the last write.
- q_valid  output  1  set once the register has been written since reset.

Behaviour:
- Reset (rst=1, asynchronous, takes effect immediately without a clk edge):
  - q=0, q_owner=0, q_valid=0, priority pointer ptr=0, lock state=UNLOCKED.
  - grant forced to 0 while rst=1.
- Arbitration:
  - Scan requesters starting at index ptr, ascending with wrap (ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1).
  - The first requester with req=1 is granted.
  - grant is exactly one-hot when any req=1, all-zero otherwise.
- Write (rising clk edge with grant nonzero, winner index g):
  - q <= data[g].
  - q_owner <= g.
  - q_valid <= 1.
  - ptr <= (g+1) mod NREQ (unless locked, see Optional Feature).
- Idle edge (no req): q, q_owner, q_valid, ptr all hold.
- Latency and handshake:
  - Grant is visible in the same cycle as req.
  - Written data appears on q one cycle later.
  - A requester keeping req=1 after being granted competes again. It will not win twice in a row while any other requester is requesting (fairness bound: it waits at most NREQ-1 grants).
- Wrap-around: grant to NREQ-1 moves ptr to 0.
- Simultaneous requests: resolved purely by ptr order; no fixed priority.
- Reset asserted mid-cycle: outputs clear immediately. Release of rst is treated as a synchronous deassertion by the environment; the first edge after release arbitrates normally from ptr=0.
- Data on non-granted requesters is don't-care and never reaches q.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined: adds a 2-state FSM, UNLOCKED and LOCKED(owner).
  - UNLOCKED -> LOCKED: on an edge where granted requester g has lock[g]=1 and req[g]=1. ptr is not advanced.
  - LOCKED: grant goes to the owner whenever req[owner]=1, regardless of other requests. If req[owner]=0, grant=0 (the resource is reserved).
  - LOCKED -> UNLOCKED: on an edge where lock[owner]=0. ptr <= (owner+1) mod NREQ on that edge. If req[owner]=1 on that same edge, the write still occurs.
  - Reset returns to UNLOCKED.
- Undefined: lock is ignored, there is no FSM, and arbitration is pure round-robin as above.

Test Plan:
(All scenarios use NREQ=4, WIDTH=8.)
- Reset: assert rst mid-run after writes -> q=0x00, q_valid=0, q_owner=0, grant=0 immediately, without a clk edge.
- Single requester: req=0001, data0=0xA5 -> grant=0001 same cycle; next cycle q=0xA5, q_owner=0, q_valid=1; ptr=1.
- Full contention for 8 cycles, req=1111, data_i=0x10+i:
  - grant sequence 0001, 0010, 0100, 1000, 0001, ...
  - q sequence 0x10, 0x11, 0x12, 0x13, 0x10, ...
- Wrap-around and skip: ptr=3 after granting 2; req=0101 -> grant=0001 (index 0); then ptr=1, req=0101 -> grant=0100.
- Idle hold: after a write of 0x3C, req=0000 for 5 cycles -> q stays 0x3C, grant=0 throughout.
- Lock (ARB_LOCK_EN defined):
  - req=0011, lock=0010, ptr=1 -> requester 1 wins 3 consecutive cycles while req0=1.
  - Drop lock1 -> next grant goes to requester 2 if requesting, otherwise requester 0.
  - With the macro undefined, the same stimulus alternates grant 0010, 0001.
